// File: rtl/add32_accum_pkg.sv
// Shared types and constants for the add32_accum stream accumulator.
// ADD32_ACCUM_SATURATE_EN (see add32_accum.sv) selects saturating accumulation.
package add32_accum_pkg;

  localparam int unsigned ADD32_W = 32;
  localparam int unsigned CLA_GRP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Result payload as presented on the output channel (count carried separately
  // because its width is a parameter of the top).
  typedef struct packed {
    logic [ADD32_W-1:0] sum;
    logic               carry;
  } result_t;

endpackage

// File: rtl/add32_accum_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carries.
module add32_accum_cla
  import add32_accum_pkg::*;
(
  input  logic [ADD32_W-1:0] A,
  input  logic [ADD32_W-1:0] B,
  output logic [ADD32_W-1:0] S,
  output logic               Cout
);

  localparam int unsigned NGRP = ADD32_W / CLA_GRP_W;

  logic [ADD32_W-1:0] g;
  logic [ADD32_W-1:0] p;
  logic [ADD32_W-1:0] c;
  logic [NGRP-1:0]    gg;
  logic [NGRP-1:0]    gp;
  logic [NGRP:0]      gc;

  assign g = A & B;
  assign p = A ^ B;

  // Group generate/propagate, group carry chain, then in-group carries.
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < int'(NGRP); j++) begin
      gp[j] = &p[j*CLA_GRP_W +: CLA_GRP_W];
      gg[j] = g[j*CLA_GRP_W+3]
            | (p[j*CLA_GRP_W+3] & g[j*CLA_GRP_W+2])
            | (p[j*CLA_GRP_W+3] & p[j*CLA_GRP_W+2] & g[j*CLA_GRP_W+1])
            | (p[j*CLA_GRP_W+3] & p[j*CLA_GRP_W+2] & p[j*CLA_GRP_W+1] & g[j*CLA_GRP_W]);
    end
    gc[0] = 1'b0;
    for (int j = 0; j < int'(NGRP); j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int i = 0; i < int'(ADD32_W); i++) begin
      if ((i % int'(CLA_GRP_W)) == 0) begin
        c[i] = gc[i / int'(CLA_GRP_W)];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
  end

  assign S    = p ^ c;
  assign Cout = gc[NGRP];

endmodule

// File: rtl/add32_accum.sv
// Stream accumulator: sums a valid/ready packet of words through the CLA and
// presents one registered result. ADD32_ACCUM_SATURATE_EN clamps acc on overflow.
module add32_accum
  import add32_accum_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADD32_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADD32_W-1:0] out_sum,
  output logic               out_carry,
  output logic [CNT_W-1:0]   out_count
);

  state_e             state_q, state_d;
  result_t            res_q, res_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [ADD32_W-1:0] cla_s;
  logic               cla_cout;
  logic               beat_c;
  logic               term_c;
  logic [CNT_W-1:0]   count_inc_c;

  add32_accum_cla u_cla (
    .A    (res_q.sum),
    .B    (in_data),
    .S    (cla_s),
    .Cout (cla_cout)
  );

  assign beat_c      = in_valid & in_ready_q;
  assign count_inc_c = count_q + CNT_W'(1);
  assign term_c      = in_last | (count_inc_c == CNT_W'(MAX_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    count_d = count_q;

    if (beat_c) begin
`ifdef ADD32_ACCUM_SATURATE_EN
      res_d.sum = cla_cout ? '1 : cla_s;
`else
      res_d.sum = cla_s;
`endif
      res_d.carry = res_q.carry | cla_cout;
      count_d     = count_inc_c;
    end

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat_c) begin
          state_d = term_c ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          res_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        res_d   = '0;
        count_d = '0;
      end
    endcase

    // Handshake flags follow the next state so they are valid right after the edge.
    in_ready_d  = (state_d != ST_DONE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = res_q.sum;
  assign out_carry = res_q.carry;
  assign out_count = count_q;

endmodule

// File: tb/tb_add32_accum.sv
// Scoreboard bench for add32_accum: directed packets, expected results queued
// at issue time and checked by a monitor on each output handshake.
module tb_add32_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic [7:0]  out_count;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic [7:0]  count;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  add32_accum #(.MAX_WORDS(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [31:0] s, input logic c, input logic [7:0] n);
    exp_t e;
    e.sum   = s;
    e.carry = c;
    e.count = n;
    sb.push_back(e);
  endtask

  // Pops one expectation per output handshake.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("mon_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("mon_sum",   out_sum,           e.sum);
          check("mon_carry", 32'(out_carry),    32'(e.carry));
          check("mon_count", 32'(out_count),    32'(e.count));
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one beat and waits (bounded) until it is accepted.
  task automatic send(input logic [31:0] d, input logic last);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (!ok) check("send_accept_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    fork
      monitor_loop();
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick(2);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       out_sum,        32'd0);
    check("rst_carry",     32'(out_carry), 32'd0);
    check("rst_count",     32'(out_count), 32'd0);
    rst = 1'b0;
    tick(1);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 1+2+3, with an in_last pulse on a non-beat cycle
    expect_result(32'd6, 1'b0, 8'd3);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    check("t1_no_valid_early", 32'(out_valid), 32'd0);
    in_last = 1'b1;
    tick(1);
    in_last = 1'b0;
    send(32'd3, 1'b1);
    check("t1_valid_latency", 32'(out_valid), 32'd1);
    check("t1_in_ready_low",  32'(in_ready),  32'd0);

    // 2: overflow
`ifdef ADD32_ACCUM_SATURATE_EN
    expect_result(32'hFFFF_FFFF, 1'b1, 8'd2);
`else
    expect_result(32'h0000_0001, 1'b1, 8'd2);
`endif
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b1);

    // Sticky carry across a later non-carrying add
`ifdef ADD32_ACCUM_SATURATE_EN
    expect_result(32'hFFFF_FFFF, 1'b1, 8'd3);
`else
    expect_result(32'h0000_0005, 1'b1, 8'd3);
`endif
    send(32'h8000_0000, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h0000_0005, 1'b1);

    // 3: forced termination at MAX_WORDS, result held under backpressure
    tick(2);
    out_ready = 1'b0;
    expect_result(32'd16, 1'b0, 8'd16);
    for (int i = 0; i < 16; i++) send(32'd1, 1'b0);
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_in_ready",  32'(in_ready),  32'd0);
    check("t3_count",     32'(out_count), 32'd16);

    // 4: five cycles of backpressure with a beat offered that must be refused
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t4_hold_valid",    32'(out_valid), 32'd1);
      check("t4_hold_sum",      out_sum,        32'd16);
      check("t4_hold_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick(1);
    check("t4_idle_valid",    32'(out_valid), 32'd0);
    check("t4_idle_in_ready", 32'(in_ready),  32'd1);
    check("t4_idle_count",    32'(out_count), 32'd0);

    // 5: reset mid-packet discards the partial sum
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    check("t5_partial_sum", out_sum, 32'd11);
    rst = 1'b1;
    #1;
    check("t5_rst_sum",       out_sum,        32'd0);
    check("t5_rst_count",     32'(out_count), 32'd0);
    check("t5_rst_in_ready",  32'(in_ready),  32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    tick(1);
    rst = 1'b0;
    expect_result(32'd15, 1'b0, 8'd2);
    send(32'd7, 1'b0);
    send(32'd8, 1'b1);

    // 6: single-word packet
    expect_result(32'h1234_5678, 1'b0, 8'd1);
    send(32'h1234_5678, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    tick(2);
    check("final_idle_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
